mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data width of each requester and of the output.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i requests transfer of d_i.
REQ-005 d0, d1, d2, d3  input  WIDTH each  requester data words.
REQ-006 fixed_pri  input  1  1 = fixed priority (0 highest); 0 = round-robin.
REQ-007 y_ready  input  1  downstream accepts y this cycle.
REQ-008 grant  output  4  one-hot, combinational; bit i high = d_i captured at this rising edge.
REQ-009 y  output  WIDTH  registered selected data.
REQ-010 y_valid  output  1  y holds an unconsumed word.
REQ-011 sel  output  2  registered index of the requester whose data is in y.

Function
REQ-012 load SHALL be defined as (!y_valid || y_ready) && (req != 0); grant SHALL be all-zero when load is 0.
REQ-013 When load is 1, exactly one grant bit SHALL be high: the winner.
REQ-014 Round-robin: the winner SHALL be the first requesting index scanning ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last winner.
REQ-015 Fixed priority: the winner SHALL be the lowest requesting index; ptr SHALL still update to every winner.
REQ-016 On a load edge: y <= d_winner, sel <= winner, y_valid <= 1, ptr <= winner; latency from req sampled to y_valid SHALL be 1 cycle.
REQ-017 y_valid && y_ready && !load: y_valid SHALL clear; y and sel SHALL hold their last value.
REQ-018 y_valid && !y_ready: y, sel and y_valid SHALL hold; grant SHALL be 0 regardless of req (backpressure).
REQ-019 Simultaneous y_ready and load: old word consumed and new word captured in the same edge; sustained throughput SHALL be 1 word/cycle.
REQ-020 A requester SHALL treat grant as its data-accepted acknowledge; a still-high req after its grant is a new request and competes again.
REQ-021 Wrap-around: ptr = 3 SHALL give index 0 first priority; a single requester SHALL win every load, regardless of ptr.
REQ-022 A change of fixed_pri SHALL take effect on the next arbitration, without flushing y.
REQ-023 d_i SHALL be sampled only at its grant edge; changes at other times SHALL not affect y.

Reset
REQ-024 While reset is high: y = 0, y_valid = 0, sel = 0, ptr = 3, and grant = 0.
REQ-025 Reset asserted mid-operation SHALL discard any held word immediately, without waiting for a clock edge.
REQ-026 First arbitration after reset SHALL favour requester 0.

Verification
REQ-027 The bench SHALL apply each of the following scenarios with d0=8'h00, d1=8'h55, d2=8'hAA, d3=8'hFF.
- Reset: assert reset with req=4'hF -> y=8'h00, y_valid=0, sel=0, grant=0 with no clock edge.
- Single request: req=4'b0100, y_ready=1 -> grant=4'b0100 that cycle; next edge y=8'hAA, sel=2, y_valid=1.
- Round-robin: req=4'hF held, y_ready=1, fixed_pri=0 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; y = 00,55,AA,FF,00.
- Backpressure: y_valid=1 with y=8'h55, y_ready=0 for 3 cycles, req=4'hF -> grant=0; y stays 8'h55; on y_ready=1, grant=4'b0100 and next y=8'hAA.
- Fixed priority: fixed_pri=1, req=4'hF, y_ready=1 -> grant=4'b0001 every cycle, y=8'h00; drop req[0] -> grant=4'b0010, y=8'h55.
- Reset mid-operation: y_valid=1, y=8'hFF, assert reset between edges -> y_valid=0 and y=0 immediately; after release, req=4'hF -> first grant=4'b0001.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four requester channels, the mode select and the registered
// output port of the 4:1 arbitrating multiplexer.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             fixed_pri;
  logic             y_ready;
  logic [3:0]       grant;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic [1:0]       sel;

  // Requesters plus downstream consumer drive the arbiter through this side.
  modport master (
    output req, d0, d1, d2, d3, fixed_pri, y_ready,
    input  grant, y, y_valid, sel
  );

  modport slave (
    input  req, d0, d1, d2, d3, fixed_pri, y_ready,
    output grant, y, y_valid, sel
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// 4:1 arbitrating multiplexer with a one-word registered output stage.
// Round-robin or fixed priority; grant is a combinational capture acknowledge.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mux4_rr_arbiter_if.slave     bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             load;
  logic [1:0]       winner;
  logic [WIDTH-1:0] win_data;

  // First requesting index after the last winner, wrapping mod 4; the last
  // winner itself is scanned last so a lone requester always wins.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) w = 2'(k);
    end
    return w;
  endfunction

  always_comb begin
    load     = (!vld_q || bus.y_ready) && (bus.req != 4'b0000);
    winner   = bus.fixed_pri ? pick_fixed(bus.req) : pick_rr(bus.req, ptr_q);
    win_data = bus.d0;
    case (winner)
      2'd0: win_data = bus.d0;
      2'd1: win_data = bus.d1;
      2'd2: win_data = bus.d2;
      2'd3: win_data = bus.d3;
      default: win_data = bus.d0;
    endcase

    y_d   = y_q;
    sel_d = sel_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load) begin
      y_d   = win_data;
      sel_d = winner;
      vld_d = 1'b1;
      ptr_d = winner;
    end else if (vld_q && bus.y_ready) begin
      vld_d = 1'b0;
    end
  end

  // Grant is masked by reset so nothing is acknowledged while the stage is held clear.
  always_comb begin
    bus.grant = 4'b0000;
    if (load && !reset) bus.grant[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q   <= '0;
      sel_q <= 2'd0;
      vld_q <= 1'b0;
      ptr_q <= 2'd3;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
  assign bus.sel     = sel_q;

endmodule
